// File: rtl/dev_reg_arbiter.sv
// dev_reg_arbiter: XM23 device register window with round-robin CPU/device write-port arbitration
module dev_reg_arbiter #(
  parameter logic [15:0] DEV_BASE = 16'h0000,
  parameter logic [15:0] DEV_TOP  = 16'h000F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_wb,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_hit,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        kb_valid,
  input  logic [7:0]  kb_byte,
  output logic        kb_ready,
  output logic        scr_valid,
  output logic [7:0]  scr_byte,
  input  logic        scr_ready,
  input  logic        tmr_tick,
  output logic        irq_kb,
  output logic        irq_scr,
  output logic        irq_tmr
);
  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;
  localparam logic [1:0] R_CPU = 2'd0, R_KB = 2'd1, R_SCR = 2'd2, R_TMR = 2'd3;
  state_t state_q, state_d;
  logic [1:0] win_q, win_d, rr_q, rr_d;
  logic cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] kb_csr_q, kb_csr_d, kb_data_q, kb_data_d, kb_hold_q, kb_hold_d;
  logic [7:0] scr_csr_q, scr_csr_d, scr_data_q, scr_data_d;
  logic [7:0] tmr_csr_q, tmr_csr_d, tmr_data_q, tmr_data_d;
  logic kb_pend_q, kb_pend_d, scr_valid_q, scr_valid_d, scr_done_q, scr_done_d;
  logic tmr_pend_q, tmr_pend_d, tmr_lost_q, tmr_lost_d;
  logic irq_kb_q, irq_kb_d, irq_scr_q, irq_scr_d, irq_tmr_q, irq_tmr_d;
  logic [15:0] off, rd_val;
  logic [15:0][7:0] regs;
  logic [5:0] touch;
  logic [3:0] idx, req, rot;
  logic [1:0] pick;
  logic [7:0] wlo, whi;
  logic odd_word, cpu_rq, serve, s_cpu, wr, rd, kb_take, scr_hs, tick;

  // CPU writes IE/ENA directly, may only clear OF, never touches DBA
  function automatic logic [7:0] csr_wr(input logic [7:0] old, input logic [7:0] w);
    return (w & 8'h11) | (old & 8'h04) | (old & w & 8'h08);
  endfunction

  assign off      = cpu_addr - DEV_BASE;
  assign cpu_hit  = off <= DEV_TOP - DEV_BASE;
  assign idx      = off[3:0];
  assign odd_word = !cpu_wb && idx[0];
  assign cpu_rq   = cpu_req && cpu_hit && !cpu_ack_q;
  assign req      = {tmr_pend_q, scr_done_q, kb_pend_q, cpu_rq};
  assign rot      = 4'({req, req} >> rr_q);
  assign pick     = rr_q + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign regs     = {80'h0, tmr_data_q, tmr_csr_q, scr_data_q, scr_csr_q, kb_data_q, kb_csr_q};
  assign touch    = 6'((16'd1 << idx) | ({15'd0, !cpu_wb} << 4'(idx + 4'd1)));
  assign rd_val   = {cpu_wb ? 8'h00 : regs[4'(idx + 4'd1)], regs[idx]};
  assign wlo      = cpu_wdata[7:0];
  assign whi      = cpu_wb ? cpu_wdata[7:0] : cpu_wdata[15:8];
  assign serve    = state_q == SERVE;
  assign s_cpu    = serve && win_q == R_CPU && !odd_word;
  assign wr       = s_cpu && cpu_we;
  assign rd       = s_cpu && !cpu_we;
  assign kb_take  = kb_valid && !kb_pend_q;
  assign scr_hs   = scr_valid_q && scr_ready;
  assign tick     = tmr_tick && tmr_csr_q[4];

  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign kb_ready  = !kb_pend_q;
  assign scr_valid = scr_valid_q;
  assign scr_byte  = scr_data_q;
  assign irq_kb    = irq_kb_q;
  assign irq_scr   = irq_scr_q;
  assign irq_tmr   = irq_tmr_q;

  // state and register file flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= R_CPU;
      rr_q        <= R_CPU;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 16'h0;
      kb_csr_q    <= 8'h00;
      kb_data_q   <= 8'h00;
      kb_hold_q   <= 8'h00;
      scr_csr_q   <= 8'h04;
      scr_data_q  <= 8'h00;
      tmr_csr_q   <= 8'h00;
      tmr_data_q  <= 8'h00;
      kb_pend_q   <= 1'b0;
      scr_valid_q <= 1'b0;
      scr_done_q  <= 1'b0;
      tmr_pend_q  <= 1'b0;
      tmr_lost_q  <= 1'b0;
      irq_kb_q    <= 1'b0;
      irq_scr_q   <= 1'b0;
      irq_tmr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      rr_q        <= rr_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      kb_csr_q    <= kb_csr_d;
      kb_data_q   <= kb_data_d;
      kb_hold_q   <= kb_hold_d;
      scr_csr_q   <= scr_csr_d;
      scr_data_q  <= scr_data_d;
      tmr_csr_q   <= tmr_csr_d;
      tmr_data_q  <= tmr_data_d;
      kb_pend_q   <= kb_pend_d;
      scr_valid_q <= scr_valid_d;
      scr_done_q  <= scr_done_d;
      tmr_pend_q  <= tmr_pend_d;
      tmr_lost_q  <= tmr_lost_d;
      irq_kb_q    <= irq_kb_d;
      irq_scr_q   <= irq_scr_d;
      irq_tmr_q   <= irq_tmr_d;
    end
  end

  // next state: latch the round-robin winner on leaving IDLE, pointer moves past it
  always_comb begin
    state_d = state_q == IDLE ? (|rot ? SERVE : IDLE) : state_q == SERVE ? ACK : IDLE;
    win_d   = (state_q == IDLE && |rot) ? pick : win_q;
    rr_d    = (state_q == IDLE && |rot) ? pick + 2'd1 : rr_q;
  end

  // outputs: CPU completion pulse follows the ACK state by one edge
  always_comb begin
    cpu_ack_d = state_q == ACK && win_q == R_CPU;
    cpu_err_d = cpu_ack_d && odd_word;
  end

  // register side effects: device events only raise pending flags, CSRs change in SERVE
  always_comb begin
    kb_csr_d    = kb_csr_q;
    kb_data_d   = kb_data_q;
    kb_hold_d   = kb_take ? kb_byte : kb_hold_q;
    kb_pend_d   = kb_pend_q || kb_take;
    scr_csr_d   = scr_csr_q;
    scr_data_d  = scr_data_q;
    scr_valid_d = scr_valid_q && !scr_hs;
    scr_done_d  = scr_done_q || scr_hs;
    tmr_csr_d   = tmr_csr_q;
    tmr_data_d  = tmr_data_q;
    tmr_pend_d  = tmr_pend_q || tick;
    tmr_lost_d  = tmr_lost_q || (tick && tmr_pend_q);
    if (wr && touch[0]) kb_csr_d = csr_wr(kb_csr_q, wlo);
    if (wr && touch[1]) kb_data_d = whi;
    if (wr && touch[2]) scr_csr_d = csr_wr(scr_csr_q, wlo);
    if (wr && touch[3]) begin
      scr_data_d  = whi;
      scr_valid_d = 1'b1;
      scr_csr_d   = (scr_csr_d & 8'h19) | (scr_csr_q[2] ? 8'h00 : 8'h08);
    end
    if (wr && touch[4]) tmr_csr_d = csr_wr(tmr_csr_q, wlo);
    if (wr && touch[5]) tmr_data_d = whi;
    if (rd && touch[1]) kb_csr_d[2] = 1'b0;
    if (rd && touch[5]) tmr_csr_d[2] = 1'b0;
    if (serve && win_q == R_KB) begin
      kb_data_d = kb_hold_q;
      kb_csr_d  = kb_csr_q | 8'h04 | (kb_csr_q[2] ? 8'h08 : 8'h00);
      kb_pend_d = 1'b0;
    end
    if (serve && win_q == R_SCR) begin
      scr_csr_d  = scr_csr_q | 8'h04;
      scr_done_d = scr_hs;
    end
    if (serve && win_q == R_TMR) begin
      tmr_data_d = tmr_data_q + 8'd1;
      tmr_csr_d  = tmr_csr_q | 8'h04 | ((tmr_csr_q[2] || tmr_lost_q) ? 8'h08 : 8'h00);
      tmr_pend_d = tick;
      tmr_lost_d = 1'b0;
    end
    cpu_rdata_d = (serve && win_q == R_CPU) ? (rd ? rd_val : 16'h0) : cpu_rdata_q;
    irq_kb_d    = kb_csr_q[0] && kb_csr_q[2];
    irq_scr_d   = scr_csr_q[0] && scr_csr_q[2];
    irq_tmr_d   = tmr_csr_q[0] && tmr_csr_q[2];
  end
endmodule

// File: tb/tb_dev_reg_arbiter.sv
// tb_dev_reg_arbiter: directed checks of the device register window and its arbiter
module tb_dev_reg_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_wb = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
  logic cpu_hit, cpu_ack, cpu_err, kb_ready, scr_valid;
  logic [15:0] cpu_rdata;
  logic kb_valid = 1'b0, scr_ready = 1'b0, tmr_tick = 1'b0;
  logic [7:0] kb_byte = 8'h0, scr_byte;
  logic irq_kb, irq_scr, irq_tmr;
  int n_cmp = 0, n_bad = 0, lat;
  logic [15:0] rd;
  logic er;
  logic ack_v [1:9], err_v [1:9], kbr_v [1:9], irq_v [1:9];
  logic [15:0] rd_v [1:9];

  dev_reg_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wb(cpu_wb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .kb_valid(kb_valid), .kb_byte(kb_byte),
    .kb_ready(kb_ready), .scr_valid(scr_valid), .scr_byte(scr_byte), .scr_ready(scr_ready),
    .tmr_tick(tmr_tick), .irq_kb(irq_kb), .irq_scr(irq_scr), .irq_tmr(irq_tmr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_acc(input logic we, input logic wb, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] r, output logic e, output int l);
    cpu_req = 1'b1; cpu_we = we; cpu_wb = wb; cpu_addr = a; cpu_wdata = wd; l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!cpu_ack && l < 20);
    chk("ack", {15'd0, cpu_ack}, 16'd1);
    r = cpu_rdata; e = cpu_err; cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic wb, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] r;
    logic e;
    int l;
    cpu_acc(1'b0, wb, a, 16'h0, r, e, l);
    chk(tag, r, exp);
  endtask

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
    logic [15:0] r;
    logic e;
    int l;
    cpu_acc(1'b1, 1'b1, a, {8'h00, d}, r, e, l);
  endtask

  task automatic kb_send(input logic [7:0] b);
    kb_valid = 1'b1; kb_byte = b;
    @(negedge clk);
    kb_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scr_take();
    scr_ready = 1'b1;
    @(negedge clk);
    scr_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", {15'd0, cpu_ack}, 16'd0);
    chk("rst_err", {15'd0, cpu_err}, 16'd0);
    chk("rst_rdata", cpu_rdata, 16'h0);
    chk("rst_kb_ready", {15'd0, kb_ready}, 16'd1);
    chk("rst_scr_valid", {15'd0, scr_valid}, 16'd0);
    chk("rst_irq", {13'd0, irq_kb, irq_scr, irq_tmr}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // 1: address decode and first read latency
    cpu_addr = 16'h0002; #1 chk("hit_in", {15'd0, cpu_hit}, 16'd1);
    cpu_addr = 16'h0010; #1 chk("hit_out", {15'd0, cpu_hit}, 16'd0);
    cpu_acc(1'b0, 1'b1, 16'h0002, 16'h0, rd, er, lat);
    chk("t1_latency", 16'(lat), 16'd3);
    chk("t1_rdata", rd, 16'h0004);
    chk("t1_err", {15'd0, er}, 16'd0);
    chk("t1_irq_scr", {15'd0, irq_scr}, 16'd0);
    // 2: keyboard overrun and read-clears-DBA
    kb_send(8'h41);
    chk("t2_kb_ready", {15'd0, kb_ready}, 16'd1);
    kb_send(8'h42);
    rd_chk("t2_kb_csr_of", 1'b1, 16'h0000, 16'h000C);
    rd_chk("t2_kb_data", 1'b1, 16'h0001, 16'h0042);
    rd_chk("t2_kb_csr_clr", 1'b1, 16'h0000, 16'h0008);
    // 3: screen output path
    wr_byte(16'h0003, 8'h5A);
    chk("t3_scr_valid", {15'd0, scr_valid}, 16'd1);
    chk("t3_scr_byte", {8'h00, scr_byte}, 16'h005A);
    rd_chk("t3_scr_csr_busy", 1'b1, 16'h0002, 16'h0000);
    scr_take();
    chk("t3_scr_valid_lo", {15'd0, scr_valid}, 16'd0);
    rd_chk("t3_scr_csr_done", 1'b1, 16'h0002, 16'h0004);
    wr_byte(16'h0003, 8'h11);
    wr_byte(16'h0003, 8'h22);
    chk("t3_scr_byte2", {8'h00, scr_byte}, 16'h0022);
    rd_chk("t3_scr_csr_of", 1'b1, 16'h0002, 16'h0008);
    scr_take();
    rd_chk("t3_scr_csr_of_done", 1'b1, 16'h0002, 16'h000C);
    // 4: timer wrap, irq timing, lost tick overrun
    cpu_acc(1'b1, 1'b0, 16'h0004, 16'hFF11, rd, er, lat);
    tmr_tick = 1'b1;
    @(negedge clk);
    tmr_tick = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_irq_early", {15'd0, irq_tmr}, 16'd0);
    @(negedge clk);
    chk("t4_irq", {15'd0, irq_tmr}, 16'd1);
    rd_chk("t4_word", 1'b0, 16'h0004, 16'h0015);
    rd_chk("t4_csr_clr", 1'b1, 16'h0004, 16'h0011);
    chk("t4_irq_lo", {15'd0, irq_tmr}, 16'd0);
    tmr_tick = 1'b1;
    repeat (2) @(negedge clk);
    tmr_tick = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("t4_csr_of", 1'b1, 16'h0004, 16'h001D);
    rd_chk("t4_data1", 1'b1, 16'h0005, 16'h0001);
    wr_byte(16'h0004, 8'h11);
    rd_chk("t4_of_clr", 1'b1, 16'h0004, 16'h0011);
    // 5: three simultaneous requesters, CPU access is an odd word read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wb = 1'b0; cpu_addr = 16'h0003;
    kb_valid = 1'b1; kb_byte = 8'h33; tmr_tick = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ack_v[k] = cpu_ack; err_v[k] = cpu_err; rd_v[k] = cpu_rdata;
      kbr_v[k] = kb_ready; irq_v[k] = irq_tmr;
      if (k == 1) begin kb_valid = 1'b0; tmr_tick = 1'b0; end
      if (cpu_ack) cpu_req = 1'b0;
    end
    chk("t5_ack2", {15'd0, ack_v[2]}, 16'd0);
    chk("t5_ack3", {15'd0, ack_v[3]}, 16'd1);
    chk("t5_err3", {15'd0, err_v[3]}, 16'd1);
    chk("t5_rdata3", rd_v[3], 16'h0000);
    chk("t5_kb_busy4", {15'd0, kbr_v[4]}, 16'd0);
    chk("t5_kb_done5", {15'd0, kbr_v[5]}, 16'd1);
    chk("t5_irq8", {15'd0, irq_v[8]}, 16'd0);
    chk("t5_irq9", {15'd0, irq_v[9]}, 16'd1);
    rd_chk("t5_kb_data", 1'b1, 16'h0001, 16'h0033);
    rd_chk("t5_tmr_data", 1'b1, 16'h0005, 16'h0002);
    // 6: reset in the middle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wb = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'h0011;
    kb_valid = 1'b1; kb_byte = 8'h77;
    @(negedge clk);
    kb_valid = 1'b0; cpu_req = 1'b0; rst_n = 1'b0;
    #1 chk("t6_kb_ready_async", {15'd0, kb_ready}, 16'd1);
    @(negedge clk);
    chk("t6_no_ack", {15'd0, cpu_ack}, 16'd0);
    chk("t6_scr_valid", {15'd0, scr_valid}, 16'd0);
    chk("t6_scr_byte", {8'h00, scr_byte}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("t6_kb_csr", 1'b1, 16'h0000, 16'h0000);
    rd_chk("t6_kb_data", 1'b1, 16'h0001, 16'h0000);
    rd_chk("t6_scr_csr", 1'b1, 16'h0002, 16'h0004);
    rd_chk("t6_tmr_word", 1'b0, 16'h0004, 16'h0000);
    chk("t6_irq", {13'd0, irq_kb, irq_scr, irq_tmr}, 16'd0);
    chk("t6_kb_ready", {15'd0, kb_ready}, 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
